// File: rtl/datapath_pkg.sv
// datapath_pkg: ALU opcodes, bus encoder bit indices and the C-operand sign extension.
package datapath_pkg;
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_SHR  = 5'b00100,
    OP_SHRA = 5'b00101,
    OP_SHL  = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_MUL  = 5'b01001,
    OP_DIV  = 5'b01010,
    OP_NEG  = 5'b01011,
    OP_NOT  = 5'b01100
  } alu_op_e;
  localparam int ENC_HI     = 16;
  localparam int ENC_LO     = 17;
  localparam int ENC_ZHIGH  = 18;
  localparam int ENC_ZLOW   = 19;
  localparam int ENC_PC     = 20;
  localparam int ENC_MDR    = 21;
  localparam int ENC_INPORT = 22;
  localparam int ENC_C      = 23;
  function automatic logic [31:0] sext19(input logic [18:0] v);
    return {{13{v[18]}}, v};
  endfunction
endpackage

// File: rtl/alu.sv
// alu: 64-bit result ALU; A is the Y register, B is the bus, IncPC overrides the opcode.
module alu
  import datapath_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  input  logic        inc_pc,
  output logic [63:0] c
);
  logic [4:0] amt;
  logic [63:0] rr, rl, prod;
  logic [31:0] sra, quo, rem;
  logic signed [31:0] sa, sb;
  assign amt = b[4:0];
  // doubling A turns both rotates into plain shifts, and amount 0 falls out as A
  assign rr = {a, a} >> amt;
  assign rl = {a, a} << amt;
  assign sra = $signed(a) >>> amt;
  assign prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign sa = a;
  assign sb = b;
  assign quo = sa / sb;
  assign rem = sa % sb;
  always_comb begin
    c = '0;
    if (inc_pc) c = {32'b0, b + 32'd1};
    else
      case (op)
        OP_ADD:  c = {32'b0, a + b};
        OP_SUB:  c = {32'b0, a - b};
        OP_AND:  c = {32'b0, a & b};
        OP_OR:   c = {32'b0, a | b};
        OP_SHR:  c = {32'b0, a >> amt};
        OP_SHRA: c = {32'b0, sra};
        OP_SHL:  c = {32'b0, a << amt};
        OP_ROR:  c = {32'b0, rr[31:0]};
        OP_ROL:  c = {32'b0, rl[63:32]};
        OP_MUL:  c = prod;
        OP_DIV:  c = (b == '0) ? '0 : {rem, quo};
        OP_NEG:  c = {32'b0, -b};
        OP_NOT:  c = {32'b0, ~b};
        default: c = '0;
      endcase
  end
endmodule

// File: rtl/datapath.sv
// datapath: single-bus CPU datapath with register file, priority bus encoder/mux and ALU.
module datapath
  import datapath_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        ZHighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R7in,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        Read,
  input  logic        IncPC,
  input  logic        AND,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  operation,
  output logic [31:0] encoder_input
);
  logic [31:0] r [16];
  logic [31:0] hi, lo, pc, ir, y, mar, mdr, zhigh, zlow, bus;
  logic [31:0] src [32];
  logic [63:0] c;
  logic [15:0] r_in;
  logic [4:0] sel;
  logic unused;
  assign encoder_input = {8'b0, Cout, InPortout, MDRout, PCout, Zlowout, ZHighout, LOout, HIout,
                          R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                          R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in = {8'b0, R7in, 2'b0, R4in, R3in, 3'b0};
  assign unused = ^{AND, ir[31:19], mar};
  always_comb begin
    sel = '0;
    for (int i = 0; i < 32; i++) if (encoder_input[i]) sel = 5'(i);
  end
  always_comb begin
    src = '{default: '0};
    for (int i = 0; i < 16; i++) src[i] = r[i];
    src[ENC_HI] = hi;
    src[ENC_LO] = lo;
    src[ENC_ZHIGH] = zhigh;
    src[ENC_ZLOW] = zlow;
    src[ENC_PC] = pc;
    src[ENC_MDR] = mdr;
    src[ENC_INPORT] = '0;
    src[ENC_C] = sext19(ir[18:0]);
  end
  assign bus = (encoder_input == '0) ? '0 : src[sel];
  alu u_alu (
    .a      (y),
    .b      (bus),
    .op     (operation),
    .inc_pc (IncPC),
    .c      (c)
  );
  // only R3, R4 and R7 have load ports; the rest stay at their reset value
  for (genvar g = 0; g < 16; g++) begin : g_r
    always_ff @(posedge Clock or negedge clear)
      if (!clear) r[g] <= '0;
      else if (r_in[g]) r[g] <= bus;
  end
  always_ff @(posedge Clock or negedge clear)
    if (!clear) begin
      hi <= '0;
      lo <= '0;
      pc <= '0;
      ir <= '0;
      y <= '0;
      mar <= '0;
      mdr <= '0;
      zhigh <= '0;
      zlow <= '0;
    end else begin
      if (PCin) pc <= bus;
      if (IRin) ir <= bus;
      if (Yin) y <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (Zin) {zhigh, zlow} <= c;
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: randomized and directed checks of datapath against a behavioural model.
module tb_datapath;
  logic Clock = 0, clear = 0;
  logic [23:0] outs = '0;
  logic [8:0] loads = '0;
  logic Read = 0, IncPC = 0, AND_s = 0;
  logic [31:0] Mdatain = '0;
  logic [4:0] operation = '0;
  logic [31:0] encoder_input;
  int errors = 0, checks = 0;
  logic [31:0] ms [10];
  logic [31:0] ds [10];
  string nm [10] = '{"R3", "R4", "R7", "PC", "IR", "Y", "MAR", "MDR", "ZHigh", "ZLow"};
  logic [31:0] enc_seen, bus_seen, exp_bus;
  localparam int O_R3 = 3, O_R4 = 4, O_R7 = 7, O_ZL = 19, O_PC = 20, O_MDR = 21;
  localparam logic [8:0] L_R3 = 9'h001, L_R4 = 9'h002, L_R7 = 9'h004, L_PC = 9'h008;
  localparam logic [8:0] L_Y = 9'h020, L_Z = 9'h040, L_MDR = 9'h100;

  datapath dut (
    .Clock(Clock), .clear(clear),
    .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]),
    .R4out(outs[4]), .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]),
    .R8out(outs[8]), .R9out(outs[9]), .R10out(outs[10]), .R11out(outs[11]),
    .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
    .HIout(outs[16]), .LOout(outs[17]), .ZHighout(outs[18]), .Zlowout(outs[19]),
    .PCout(outs[20]), .MDRout(outs[21]), .InPortout(outs[22]), .Cout(outs[23]),
    .R3in(loads[0]), .R4in(loads[1]), .R7in(loads[2]), .PCin(loads[3]), .IRin(loads[4]),
    .Yin(loads[5]), .Zin(loads[6]), .MARin(loads[7]), .MDRin(loads[8]),
    .Read(Read), .IncPC(IncPC), .AND(AND_s), .Mdatain(Mdatain), .operation(operation),
    .encoder_input(encoder_input)
  );

  assign ds[0] = dut.r[3];
  assign ds[1] = dut.r[4];
  assign ds[2] = dut.r[7];
  assign ds[3] = dut.pc;
  assign ds[4] = dut.ir;
  assign ds[5] = dut.y;
  assign ds[6] = dut.mar;
  assign ds[7] = dut.mdr;
  assign ds[8] = dut.zhigh;
  assign ds[9] = dut.zlow;

  always #5 Clock = ~Clock;

  function automatic logic [31:0] c_src();
    logic signed [18:0] t;
    logic signed [31:0] x;
    t = ms[4][18:0];
    x = t;
    return x;
  endfunction

  // the highest-numbered asserted select wins; unmodelled sources read zero
  function automatic logic [31:0] bus_ref(input logic [23:0] o);
    logic [31:0] v;
    logic found;
    v = '0;
    found = 0;
    for (int k = 23; k >= 0; k--)
      if (o[k] && !found) begin
        found = 1;
        case (k)
          3: v = ms[0];
          4: v = ms[1];
          7: v = ms[2];
          18: v = ms[8];
          19: v = ms[9];
          20: v = ms[3];
          21: v = ms[7];
          23: v = c_src();
          default: v = '0;
        endcase
      end
    return v;
  endfunction

  function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op, input logic inc);
    int sa, sb, n;
    longint p;
    logic [31:0] t;
    sa = a;
    sb = b;
    n = int'(b[4:0]);
    t = a;
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      5'd0: return {32'd0, a + b};
      5'd1: return {32'd0, a - b};
      5'd2: return {32'd0, a & b};
      5'd3: return {32'd0, a | b};
      5'd4: return {32'd0, a >> n};
      5'd5: return {32'd0, 32'(sa >>> n)};
      5'd6: return {32'd0, a << n};
      5'd7: begin
        for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
        return {32'd0, t};
      end
      5'd8: begin
        for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
        return {32'd0, t};
      end
      5'd9: begin
        p = longint'(sa) * longint'(sb);
        return 64'(p);
      end
      5'd10: return (sb == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      5'd11: return {32'd0, 32'd0 - b};
      5'd12: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  task automatic cyc(input logic [23:0] o, input logic [8:0] ld, input logic rd,
                     input logic inc, input logic [4:0] op, input logic [31:0] md);
    logic [31:0] b;
    logic [63:0] z;
    outs = o;
    loads = ld;
    Read = rd;
    IncPC = inc;
    operation = op;
    Mdatain = md;
    AND_s = 1'($urandom_range(0, 1));
    #1;
    enc_seen = encoder_input;
    bus_seen = dut.bus;
    exp_bus = bus_ref(o);
    b = exp_bus;
    z = alu_ref(ms[5], b, op, inc);
    @(posedge Clock);
    #1;
    for (int i = 0; i < 6; i++) if (ld[i]) ms[i] = b;
    if (ld[6]) {ms[8], ms[9]} = z;
    if (ld[7]) ms[6] = b;
    if (ld[8]) ms[7] = rd ? md : b;
    outs = '0;
    loads = '0;
    Read = 0;
    IncPC = 0;
    operation = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) ms[i] = '0;
    outs = 24'h800010;
    repeat (2) @(posedge Clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ds[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_%s: got %h expected 00000000", nm[i], ds[i]);
      end
    end
    checks++;
    if (encoder_input !== 32'h00800010) begin
      errors++;
      $display("FAIL reset_encoder: got %h expected 00800010", encoder_input);
    end
    outs = '0;
    @(negedge Clock);
    clear = 1;
  endtask

  task automatic test_load_sequence();
    cyc(0, L_MDR, 1, 0, 0, 32'h22);
    cyc(24'(1) << O_MDR, L_R3, 0, 0, 0, 0);
    cyc(0, L_MDR, 1, 0, 0, 32'h24);
    cyc(24'(1) << O_MDR, L_R7, 0, 0, 0, 0);
    cyc(0, L_MDR, 1, 0, 0, 32'h28);
    cyc(24'(1) << O_MDR, L_R4, 0, 0, 0, 0);
    checks++;
    if (ds[0] !== 32'h22) begin errors++; $display("FAIL seq_R3: got %h expected 00000022", ds[0]); end
    checks++;
    if (ds[2] !== 32'h24) begin errors++; $display("FAIL seq_R7: got %h expected 00000024", ds[2]); end
    checks++;
    if (ds[1] !== 32'h28) begin errors++; $display("FAIL seq_R4: got %h expected 00000028", ds[1]); end
  endtask

  task automatic test_rol();
    cyc(24'(1) << O_R3, L_Y, 0, 0, 0, 0);
    cyc(24'(1) << O_R7, L_Z, 0, 0, 5'b01000, 0);
    checks++;
    if (ds[8] !== 32'd0) begin errors++; $display("FAIL rol_zhigh: got %h expected 00000000", ds[8]); end
    cyc(24'(1) << O_ZL, L_R4, 0, 0, 0, 0);
    checks++;
    if (ds[1] !== 32'h220) begin errors++; $display("FAIL rol_R4: got %h expected 00000220", ds[1]); end
  endtask

  task automatic test_mul_div();
    cyc(0, L_MDR, 1, 0, 0, 32'hFFFFFFFE);
    cyc(24'(1) << O_MDR, L_Y, 0, 0, 0, 0);
    cyc(0, L_MDR, 1, 0, 0, 32'd3);
    cyc(24'(1) << O_MDR, L_Z, 0, 0, 5'b01001, 0);
    checks++;
    if (ds[8] !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_zhigh: got %h expected ffffffff", ds[8]); end
    checks++;
    if (ds[9] !== 32'hFFFFFFFA) begin errors++; $display("FAIL mul_zlow: got %h expected fffffffa", ds[9]); end
    cyc(0, L_MDR, 1, 0, 0, 32'd7);
    cyc(24'(1) << O_MDR, L_Y, 0, 0, 0, 0);
    cyc(0, L_Z, 0, 0, 5'b01010, 0);
    checks++;
    if ({ds[8], ds[9]} !== 64'd0) begin
      errors++;
      $display("FAIL div_by_zero: got %h%h expected 0000000000000000", ds[8], ds[9]);
    end
  endtask

  task automatic test_priority();
    cyc((24'(1) << O_MDR) | (24'(1) << O_R3), 0, 0, 0, 0, 0);
    checks++;
    if (enc_seen !== 32'h00200008) begin errors++; $display("FAIL prio_encoder: got %h expected 00200008", enc_seen); end
    checks++;
    if (bus_seen !== 32'd7) begin errors++; $display("FAIL prio_bus: got %h expected 00000007", bus_seen); end
  endtask

  task automatic test_incpc_clear();
    cyc(0, L_MDR, 1, 0, 0, 32'd5);
    cyc(24'(1) << O_MDR, L_PC, 0, 0, 0, 0);
    cyc(24'(1) << O_PC, L_Z, 0, 1, 5'b00010, 0);
    cyc(24'(1) << O_ZL, L_PC, 0, 0, 0, 0);
    checks++;
    if (ds[3] !== 32'd6) begin errors++; $display("FAIL incpc_PC: got %h expected 00000006", ds[3]); end
    outs = 24'(1) << O_PC;
    loads = L_Z;
    IncPC = 1;
    #2;
    clear = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      ms[i] = '0;
      checks++;
      if (ds[i] !== 32'd0) begin
        errors++;
        $display("FAIL async_clear_%s: got %h expected 00000000", nm[i], ds[i]);
      end
    end
    outs = '0;
    loads = '0;
    IncPC = 0;
    @(negedge Clock);
    clear = 1;
  endtask

  task automatic test_random();
    int idx [10] = '{3, 4, 7, 16, 18, 19, 20, 21, 22, 23};
    logic [23:0] o;
    int mode;
    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 3);
      o = '0;
      if (mode >= 1) o = 24'(1) << idx[$urandom_range(0, 9)];
      if (mode >= 2) o = o | (24'(1) << $urandom_range(0, 23));
      cyc(o, 9'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 15)), $urandom);
      checks++;
      if (enc_seen !== {8'd0, o}) begin
        errors++;
        $display("FAIL rand_encoder #%0d: got %h expected %h", n, enc_seen, {8'd0, o});
      end
      checks++;
      if (bus_seen !== exp_bus) begin
        errors++;
        $display("FAIL rand_bus #%0d: got %h expected %h", n, bus_seen, exp_bus);
      end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (ds[i] !== ms[i]) begin
          errors++;
          $display("FAIL rand_%s #%0d: got %h expected %h", nm[i], n, ds[i], ms[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_rol();
    test_mul_div();
    test_priority();
    test_incpc_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
